// File: rtl/ps2_decode.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ps2_decode                                                    |
// | Purpose  : Receives PS/2 keyboard frames in the pclk domain and turns    |
// |            make/break codes for keys 1..7 into a held 3-bit key code     |
// |            for the VGA stage.                                            |
// | Ports    : pclk      - 25 MHz pixel clock, sole clock                    |
// |            rst_n     - asynchronous active-low reset                     |
// |            ps2_clk   - raw PS/2 clock (asynchronous)                     |
// |            ps2_data  - raw PS/2 data (asynchronous)                      |
// |            decode    - held key code, 0 = no key                         |
// |            valid     - one-cycle pulse whenever decode changes           |
// |            frame_err - one-cycle pulse when a frame is discarded         |
// | Params   : TIMEOUT   - mid-frame idle limit in pclk cycles               |
// | Options  : PS2_PARITY_CHECK_EN - when defined, frames failing odd parity |
// |            are discarded; otherwise the parity bit is ignored.           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module ps2_decode #(
  parameter int TIMEOUT = 25000
) (
  input  logic       pclk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [2:0] decode,
  output logic       valid,
  output logic       frame_err
);

  // Counter is at least 15 bits and always wide enough to hold TIMEOUT.
  localparam int c_TW_MIN = $clog2(TIMEOUT + 1);
  localparam int c_TW     = (c_TW_MIN > 15) ? c_TW_MIN : 15;
  localparam logic [c_TW-1:0] c_TLIM = c_TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  // Synchronisers; reset to 1 so the idle-high bus never looks like an edge.
  logic r_clk_s1, r_clk_s2, r_clk_prev;
  logic r_dat_s1, r_dat_s2;

  state_t          r_state;
  logic [7:0]      r_shift;
  logic [2:0]      r_bitcnt;
  logic            r_par;
  logic [c_TW-1:0] r_tcnt;
  logic            r_brk;
  logic [2:0]      r_decode;
  logic            r_valid;
  logic            r_err;

  logic            w_fall;
  logic [2:0]      w_code;
  logic            w_par_ok;

  function automatic logic [2:0] f_map(input logic [7:0] b);
    case (b)
      8'h16:   f_map = 3'd1;
      8'h1E:   f_map = 3'd2;
      8'h26:   f_map = 3'd3;
      8'h25:   f_map = 3'd4;
      8'h2E:   f_map = 3'd5;
      8'h36:   f_map = 3'd6;
      8'h3D:   f_map = 3'd7;
      default: f_map = 3'd0;
    endcase
  endfunction

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
    end else begin
      r_clk_s1   <= ps2_clk;
      r_clk_s2   <= r_clk_s1;
      r_clk_prev <= r_clk_s2;
      r_dat_s1   <= ps2_data;
      r_dat_s2   <= r_dat_s1;
    end
  end

  assign w_fall = r_clk_prev & ~r_clk_s2;
  assign w_code = f_map(r_shift);

`ifdef PS2_PARITY_CHECK_EN
  // Parity bit plus the eight data bits must contain an odd number of ones.
  assign w_par_ok = ^{r_par, r_shift};
`else
  logic w_par_unused;
  assign w_par_unused = r_par;
  assign w_par_ok     = 1'b1;
`endif

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_par    <= 1'b0;
      r_tcnt   <= '0;
      r_brk    <= 1'b0;
      r_decode <= '0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;

      // Idle-time counter: only meaningful inside a frame, saturates at max.
      if (r_state == ST_IDLE || w_fall) begin
        r_tcnt <= '0;
      end else if (r_tcnt != '1) begin
        r_tcnt <= r_tcnt + 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_fall && !r_dat_s2) begin
            r_state  <= ST_DATA;
            r_bitcnt <= '0;
          end
        end
        ST_DATA: begin
          if (w_fall) begin
            r_shift  <= {r_dat_s2, r_shift[7:1]};
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) begin
              r_state <= ST_PARITY;
            end
          end
        end
        ST_PARITY: begin
          if (w_fall) begin
            r_par   <= r_dat_s2;
            r_state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (w_fall) begin
            r_state <= ST_IDLE;
            if (r_dat_s2 && w_par_ok) begin
              if (r_shift == 8'hF0) begin
                r_brk <= 1'b1;
              end else if (r_brk) begin
                // Release only clears the key currently shown.
                r_brk <= 1'b0;
                if (w_code != 3'd0 && w_code == r_decode) begin
                  r_decode <= 3'd0;
                  r_valid  <= 1'b1;
                end
              end else if (w_code != 3'd0 && w_code != r_decode) begin
                r_decode <= w_code;
                r_valid  <= 1'b1;
              end
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // A stalled frame is abandoned; no edge this cycle, so no conflict
      // with the stop-bit handling above.
      if (r_state != ST_IDLE && !w_fall && r_tcnt >= c_TLIM) begin
        r_state <= ST_IDLE;
        r_tcnt  <= '0;
        r_err   <= 1'b1;
      end
    end
  end

  assign decode    = r_decode;
  assign valid     = r_valid;
  assign frame_err = r_err;

endmodule
`default_nettype wire

// File: doc/ps2_decode.md
PS2_DECODE -- requirements
Module: ps2_decode

Interface
REQ-001 SHALL have parameter TIMEOUT, default 25000, mid-frame idle limit in pclk cycles (1 ms at 25 MHz).
REQ-002 SHALL have port pclk, input, 1, sole clock, 25 MHz pixel clock shared with the VGA stage.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port ps2_clk, input, 1, raw PS/2 keyboard clock, asynchronous to pclk.
REQ-005 SHALL have port ps2_data, input, 1, raw PS/2 keyboard data, asynchronous to pclk.
REQ-006 SHALL have port decode, output, 3, held key code feeding the VGA stage (0 = no key).
REQ-007 SHALL have port valid, output, 1, one-cycle pulse on every decode change.
REQ-008 SHALL have port frame_err, output, 1, one-cycle pulse on a discarded frame.

Function
REQ-009 SHALL synchronise ps2_clk and ps2_data through two flip-flops each before any use.
REQ-010 SHALL detect a ps2_clk falling edge as synchronised value 0 with previous value 1; all bit sampling occurs only on that edge.
REQ-011 SHALL implement FSM states IDLE, DATA, PARITY, STOP.
REQ-012 IDLE: a falling edge with data 0 (start bit) enters DATA and clears the bit count; a falling edge with data 1 stays in IDLE with no error.
REQ-013 DATA: SHALL shift 8 bits LSB first; after the 8th bit, enter PARITY.
REQ-014 PARITY: SHALL capture the parity bit and enter STOP.
REQ-015 STOP: stop bit 1 SHALL make the frame good; stop bit 0 SHALL discard the frame and pulse frame_err; both return to IDLE.
REQ-016 SHALL map good bytes 0x16,0x1E,0x26,0x25,0x2E,0x36,0x3D (keys 1..7) to codes 1..7; all other bytes are unmapped.
REQ-017 A good byte 0xF0 SHALL set a break flag; the next good byte clears it and, if it maps to the current decode, sets decode to 0.
REQ-018 A break-flagged byte not matching the current decode SHALL leave decode unchanged.
REQ-019 A good mapped make byte SHALL load decode; an unmapped byte or 0xE0 prefix SHALL leave decode unchanged and not pulse frame_err.
REQ-020 decode SHALL update, and valid pulse, on the pclk cycle after the stop-bit edge; there is no valid pulse if the new value equals the old one.
REQ-021 SHALL count pclk cycles since the last falling edge while not in IDLE, saturating; reaching TIMEOUT SHALL return to IDLE, pulse frame_err and leave decode unchanged.
REQ-022 The timeout counter SHALL be at least 15 bits wide and clear on every falling edge and in IDLE.
REQ-023 frame_err and valid SHALL never be asserted in the same cycle.

Reset
REQ-024 rst_n low SHALL immediately force: FSM IDLE, decode 0, valid 0, frame_err 0, break flag 0, counters 0, synchronisers 1.
REQ-025 Reset mid-frame SHALL abandon the frame; after release, reception restarts at the next start bit with no error pulse.

Configuration
REQ-026 Macro PS2_PARITY_CHECK_EN defined: the parity bit plus the 8 data bits SHALL have odd total parity, else the frame is discarded with a frame_err pulse in STOP.
REQ-027 Macro PS2_PARITY_CHECK_EN undefined: the parity bit SHALL be captured and ignored; only start, stop and timeout errors apply.

Verification
REQ-028 Frame 0x1E, correct parity, 40 us bit period -> decode 2 with one valid pulse one cycle after the stop edge.
REQ-029 Frames 0x1E, then 0xF0, then 0x1E -> decode returns 0 with a second valid pulse; break 0x16 while decode is 2 -> decode stays 2.
REQ-030 Frame 0x26 with wrong parity -> with PS2_PARITY_CHECK_EN: frame_err pulse, decode unchanged; without it: decode 3.
REQ-031 Frame 0x25 with stop bit 0 -> frame_err pulse, decode unchanged, next good frame 0x25 -> decode 4.
REQ-032 Start bit plus 3 data bits, then ps2_clk held high for TIMEOUT+10 cycles -> frame_err pulse at TIMEOUT, FSM IDLE, next frame 0x3D -> decode 7.
REQ-033 rst_n pulsed low after bit 5 of frame 0x2E -> decode 0 immediately, no pulses, next full frame 0x36 -> decode 6.
